// File: rtl/dcache_write_buffer.sv
// Store write buffer between commit and the dcache: circular FIFO with
// tail-entry merging, a zero-latency head issue port and a load-ordering probe.
module dcache_write_buffer #(
  parameter int unsigned WB_ENTRIES = 4,
  parameter int unsigned PA_WIDTH   = 34
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          enq_valid,
  input  logic [PA_WIDTH-1:0]           enq_PA,
  input  logic [31:0]                   enq_data,
  input  logic [3:0]                    enq_byte_mask,
  output logic                          enq_ready,
  output logic                          dcache_req_valid,
  output logic                          dcache_req_bank,
  output logic [PA_WIDTH-1:0]           dcache_req_PA,
  output logic [31:0]                   dcache_req_data,
  output logic [3:0]                    dcache_req_byte_mask,
  input  logic                          dcache_req_ready,
  input  logic [PA_WIDTH-1:0]           check_PA,
  output logic                          check_conflict,
  output logic                          empty,
  output logic [$clog2(WB_ENTRIES):0]   count
);

  localparam int unsigned AW = $clog2(WB_ENTRIES);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = PA_WIDTH - 2;

  // Pointers carry the wrap bit in their MSB.
  logic [CW-1:0]         head_q, tail_q;
  logic [AW-1:0]         head_idx, tail_idx, last_idx;
  logic [WB_ENTRIES-1:0] valid_q;
  logic [WW-1:0]         word_q [WB_ENTRIES];
  logic [31:0]           data_q [WB_ENTRIES];
  logic [3:0]            mask_q [WB_ENTRIES];

  logic          full, merge_c, deq, enq_fire, do_alloc, do_merge;
  logic [WW-1:0] enq_word, check_word;
  logic          unused_pa_lsbs;

  assign unused_pa_lsbs = ^{enq_PA[1:0], check_PA[1:0]};

  assign head_idx   = head_q[AW-1:0];
  assign tail_idx   = tail_q[AW-1:0];
  assign last_idx   = tail_idx - AW'(1);
  assign enq_word   = enq_PA[PA_WIDTH-1:2];
  assign check_word = check_PA[PA_WIDTH-1:2];

  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);
  assign count = tail_q - head_q;

  // With two or more entries the newest one is never the (possibly in-flight) head.
  assign merge_c   = (count >= CW'(2)) && (word_q[last_idx] == enq_word);
  assign enq_ready = !full || merge_c;

  assign enq_fire = enq_valid && enq_ready;
  assign do_merge = enq_fire && merge_c;
  assign do_alloc = enq_fire && !merge_c;
  assign deq      = !empty && dcache_req_ready;

  assign dcache_req_valid     = !empty;
  assign dcache_req_PA        = {word_q[head_idx], 2'b00};
  assign dcache_req_bank      = word_q[head_idx][3];
  assign dcache_req_data      = data_q[head_idx];
  assign dcache_req_byte_mask = mask_q[head_idx];

  // Head entry stays visible to the probe during its dequeue cycle.
  always_comb begin
    check_conflict = 1'b0;
    for (int i = 0; i < int'(WB_ENTRIES); i++) begin
      if (valid_q[i] && (word_q[i] == check_word) && (|mask_q[i])) begin
        check_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      if (deq) begin
        head_q            <= head_q + CW'(1);
        valid_q[head_idx] <= 1'b0;
      end
      if (do_alloc) begin
        tail_q            <= tail_q + CW'(1);
        valid_q[tail_idx] <= 1'b1;
      end
    end
  end

  // Entry payload needs no reset; valid bits and pointers gate its use.
  always_ff @(posedge CLK) begin
    if (do_alloc) begin
      word_q[tail_idx] <= enq_word;
      data_q[tail_idx] <= enq_data;
      mask_q[tail_idx] <= enq_byte_mask;
    end else if (do_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (enq_byte_mask[b]) begin
          data_q[last_idx][8*b +: 8] <= enq_data[8*b +: 8];
        end
      end
      mask_q[last_idx] <= mask_q[last_idx] | enq_byte_mask;
    end
  end

endmodule

// File: doc/dcache_write_buffer.md
DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

Interface
REQ-001 Parameter: WB_ENTRIES, 4, buffer depth; power of 2, minimum 2.
REQ-002 Parameter: PA_WIDTH, 34, physical address width.
REQ-003 CLK  in  1  single clock; all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 enq_valid  in  1  committed store offered.
REQ-006 enq_PA  in  PA_WIDTH  store physical address; bits [1:0] ignored.
REQ-007 enq_data  in  32  store word, byte-lane aligned.
REQ-008 enq_byte_mask  in  4  byte enables.
REQ-009 enq_ready  out  1  store accepted when enq_valid and enq_ready are both high.
REQ-010 dcache_req_valid  out  1  head entry offered to dcache.
REQ-011 dcache_req_bank  out  1  dcache bank = head PA[5].
REQ-012 dcache_req_PA  out  PA_WIDTH  head word address; bits [1:0] forced 0.
REQ-013 dcache_req_data  out  32  head data.
REQ-014 dcache_req_byte_mask  out  4  head byte enables.
REQ-015 dcache_req_ready  in  1  dcache accepts head this cycle.
REQ-016 check_PA  in  PA_WIDTH  load address probed for ordering.
REQ-017 check_conflict  out  1  load must stall; a buffered store hits the same word.
REQ-018 empty  out  1  no valid entries.
REQ-019 count  out  $clog2(WB_ENTRIES)+1  number of valid entries.

Function
REQ-020 Storage is a circular FIFO: head/tail pointers with wrap bit; full when pointers are equal and wrap bits differ, empty when pointers and wrap bits are equal.
REQ-021 dcache_req_* outputs are combinational from the head entry; dcache_req_valid = !empty; zero-cycle issue latency.
REQ-022 Dequeue: dcache_req_valid && dcache_req_ready advances head by one, with wrap-around from WB_ENTRIES-1 to 0.
REQ-023 Merge condition: count >= 2, and newest entry (tail-1) word address PA[33:2] equals enq_PA[33:2].
REQ-024 Merge: for each set mask bit, the entry byte is replaced by the enq byte and the mask bit is ORed in; tail and count are unchanged.
REQ-025 The head entry is never merged into, because it may be in flight; with count == 1, a matching store allocates a new entry.
REQ-026 Allocate, when not merging: write the entry at tail, advance tail, increment count.
REQ-027 enq_ready = !full || merge condition; it does not depend on dcache_req_ready.
REQ-028 Simultaneous enqueue and dequeue: count net unchanged on allocate; on merge, count decrements by one.
REQ-029 Simultaneous enqueue and dequeue: if dequeue takes the entry at tail-1 in the same cycle, merge is still legal only when tail-1 != head.
REQ-030 check_conflict is combinational: high if any valid entry, including the head entry being dequeued this cycle, matches check_PA[33:2] with a nonzero mask.
REQ-031 An entry enqueued in cycle N is visible to check_conflict from cycle N+1.
REQ-032 Empty buffer: dcache_req_valid = 0, and outputs dcache_req_PA, dcache_req_data and dcache_req_byte_mask are don't-care.
REQ-033 dcache_req_ready with dcache_req_valid low has no effect.
REQ-034 Zero byte mask enqueue is accepted and allocated normally.
REQ-035 count never exceeds WB_ENTRIES and never underflows.

Reset
REQ-036 RST high immediately clears all valid state, head = tail = 0 with wrap bits 0, and count = 0.
REQ-037 Outputs during and after reset: enq_ready = 1, dcache_req_valid = 0, empty = 1, check_conflict = 0, count = 0.
REQ-038 Reset mid-operation discards all buffered stores; entry data/mask contents need not reset.
REQ-039 The first post-reset enqueue lands in entry 0.

Verification
REQ-040 Fill: 4 stores to 0x100, 0x120, 0x140, 0x160 with dcache_req_ready = 0 -> count = 4 and enq_ready = 0; dcache_req_PA = 0x100 with bank 0; dcache_req_PA = 0x120 with bank 1.
REQ-041 Merge: store 0x200 mask 0001 data 0xAA, then 0x300 mask 0001, then 0x302 mask 0100 data 0x00BB0000 -> count = 2; second entry has mask 0101 and data bytes [23:16] = 0xBB.
REQ-042 No head merge: single entry at 0x400, then store 0x400 -> count = 2 and two separate dcache requests.
REQ-043 Full with simultaneous dequeue: enq_ready stays 0 for a non-merging store; the next cycle count = 3 and enq_ready = 1.
REQ-044 Conflict: buffered store at 0x500 -> check_PA 0x503 gives 1, check_PA 0x504 gives 0; after the entry drains, 0x503 gives 0.
REQ-045 Async reset: assert RST between clock edges with count = 3 -> empty = 1 and dcache_req_valid = 0 before the next edge.
